// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - bus bundle for the scoreboarded register file
//
// Purpose: groups the read, write and reserve signals of register_file_sb.
// Ports (signals):
//   Reg_address          read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   Reg_output           read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   Reg_busy             per-port busy flag of the addressed register
//   Reg_Write            write enable
//   Reg_input_address    write address
//   Reg_input_data       write data
//   Reg_Reserve          reserve request (marks a destination pending)
//   Reg_reserve_address  register to mark pending
//   Reg_any_busy         OR of all busy bits
// Modports: master (requester side), slave (register file side).
interface register_file_sb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_PORTS = 3
);
  logic [READ_PORTS*ADDR_WIDTH-1:0] Reg_address;
  logic [READ_PORTS*DATA_WIDTH-1:0] Reg_output;
  logic [READ_PORTS-1:0]            Reg_busy;
  logic                             Reg_Write;
  logic [ADDR_WIDTH-1:0]            Reg_input_address;
  logic [DATA_WIDTH-1:0]            Reg_input_data;
  logic                             Reg_Reserve;
  logic [ADDR_WIDTH-1:0]            Reg_reserve_address;
  logic                             Reg_any_busy;

  modport master (
    output Reg_address, Reg_Write, Reg_input_address, Reg_input_data,
           Reg_Reserve, Reg_reserve_address,
    input  Reg_output, Reg_busy, Reg_any_busy
  );

  modport slave (
    input  Reg_address, Reg_Write, Reg_input_address, Reg_input_data,
           Reg_Reserve, Reg_reserve_address,
    output Reg_output, Reg_busy, Reg_any_busy
  );
endinterface

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-read-port register file with busy scoreboard
//
// Purpose: 2**ADDR_WIDTH registers of DATA_WIDTH bits, register 0 hardwired to
// zero, READ_PORTS combinational read ports, one write port and one reserve
// port that marks a register as pending until it is written.
// Ports:
//   CLK    rising-edge clock
//   Reset  asynchronous active-low reset
//   bus    register_file_sb_if.slave (read/write/reserve signals)
// Optional feature: define REGFILE_BYPASS_EN to forward write data (and the
// post-write busy state) to read ports addressing the register being written.
module register_file_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_PORTS = 3
) (
  input  logic                CLK,
  input  logic                Reset,
  register_file_sb_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;

  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]                 rd_busy;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (bus.Reg_Write && (bus.Reg_input_address != '0)) begin
      regs_d[bus.Reg_input_address] = bus.Reg_input_data;
      busy_d[bus.Reg_input_address] = 1'b0;
    end
    // Applied after the write so a same-address reserve leaves the bit set:
    // the reserving instruction is the new producer.
    if (bus.Reg_Reserve && (bus.Reg_reserve_address != '0)) begin
      busy_d[bus.Reg_reserve_address] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = bus.Reg_address[p*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    // Gated by Reset so outputs stay zero while reset is asserted.
    assign hit = Reset && bus.Reg_Write && (bus.Reg_input_address != '0)
                 && (ra == bus.Reg_input_address);
    assign rd_data[p] = hit ? bus.Reg_input_data : regs_q[ra];
    assign rd_busy[p] = hit ? (bus.Reg_Reserve && (bus.Reg_reserve_address == ra))
                            : busy_q[ra];
`else
    assign rd_data[p] = regs_q[ra];
    assign rd_busy[p] = busy_q[ra];
`endif
  end

  assign bus.Reg_output   = rd_data;
  assign bus.Reg_busy     = rd_busy;
  assign bus.Reg_any_busy = |busy_q[DEPTH-1:1];
endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb
module tb_register_file_sb;
  logic CLK;
  logic Reset;

  register_file_sb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(3)) bus ();

  register_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(3)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        rs;
    logic [2:0]  rsa;
    logic [2:0]  ra0, ra1, ra2;
    logic [15:0] e0, e1, e2;
    logic [2:0]  eb;
    logic        ea;
  } vec_t;

  typedef struct {
    logic [15:0] e0, e1, e2;
    logic [2:0]  eb;
    logic        ea;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic rs, input logic [2:0] rsa,
                       input logic [2:0] ra0, input logic [2:0] ra1, input logic [2:0] ra2);
    bus.Reg_Write           = we;
    bus.Reg_input_address   = wa;
    bus.Reg_input_data      = wd;
    bus.Reg_Reserve         = rs;
    bus.Reg_reserve_address = rsa;
    bus.Reg_address         = {ra2, ra1, ra0};
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [2:0] eb, input logic ea);
    chk({tag, "_out0"}, 32'(bus.Reg_output[15:0]),  32'(e0));
    chk({tag, "_out1"}, 32'(bus.Reg_output[31:16]), 32'(e1));
    chk({tag, "_out2"}, 32'(bus.Reg_output[47:32]), 32'(e2));
    chk({tag, "_busy"}, 32'(bus.Reg_busy),          32'(eb));
    chk({tag, "_any"},  32'(bus.Reg_any_busy),      32'(ea));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // we wa    wd        rs   rsa   ra0   ra1   ra2   e0        e1        e2        eb      ea
    vecs[0] = '{1'b1, 3'd1, 16'h0001, 1'b0, 3'd0, 3'd1, 3'd0, 3'd1, 16'h0001, 16'h0000, 16'h0001, 3'b000, 1'b0};
    vecs[1] = '{1'b1, 3'd6, 16'hFFFF, 1'b0, 3'd0, 3'd1, 3'd6, 3'd1, 16'h0001, 16'hFFFF, 16'h0001, 3'b000, 1'b0};
    vecs[2] = '{1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd1, 3'd6, 16'h0000, 16'h0001, 16'hFFFF, 3'b001, 1'b1};
    vecs[4] = '{1'b1, 3'd5, 16'h00AA, 1'b0, 3'd0, 3'd5, 3'd5, 3'd0, 16'h00AA, 16'h00AA, 16'h0000, 3'b000, 1'b0};
    vecs[5] = '{1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 3'd2, 3'd5, 3'd1, 16'h5555, 16'h00AA, 16'h0001, 3'b001, 1'b1};
    vecs[6] = '{1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd7, 3'd3, 3'd7, 3'd2, 16'hBEEF, 16'h0000, 16'h5555, 3'b110, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd7, 3'd3, 3'd4, 16'h0000, 16'hBEEF, 16'h0000, 3'b001, 1'b1};

    // Reset held with a write pending: nothing may be stored.
    Reset = 1'b0;
    drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd1, 3'd1, 3'd1, 3'd1);
    #1;
    chk_outs("reset_state", 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);
    @(posedge CLK); #1;
    chk_outs("reset_ignores_write", 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);
    @(negedge CLK);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1);
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk_outs("post_reset_idle", 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);

    // Table vectors with a scoreboard queue of expected post-edge results.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].rsa,
            vecs[i].ra0, vecs[i].ra1, vecs[i].ra2);
      sb_q.push_back('{vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].eb, vecs[i].ea});
      @(posedge CLK); #1;
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk_outs($sformatf("vec%0d", i), e.e0, e.e1, e.e2, e.eb, e.ea);
      end
    end

    // Same-cycle visibility of a write to r4 (old value 0).
    @(negedge CLK);
    drive(1'b1, 3'd4, 16'hC0DE, 1'b0, 3'd0, 3'd4, 3'd3, 3'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk_outs("bypass_same_cycle", 16'hC0DE, 16'hBEEF, 16'h0000, 3'b100, 1'b1);
`else
    chk_outs("bypass_same_cycle", 16'h0000, 16'hBEEF, 16'h0000, 3'b100, 1'b1);
`endif
    @(posedge CLK); #1;
    chk_outs("bypass_after_edge", 16'hC0DE, 16'hBEEF, 16'h0000, 3'b100, 1'b1);

    // Asynchronous reset mid-cycle with a write and reserve in flight.
    @(negedge CLK);
    drive(1'b1, 3'd3, 16'h1111, 1'b1, 3'd6, 3'd3, 3'd7, 3'd4);
    #2;
    Reset = 1'b0;
    #1;
    chk_outs("async_reset", 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);
    @(posedge CLK); #1;
    chk_outs("reset_hold_edge", 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);
    @(negedge CLK);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd6, 3'd4);
    Reset = 1'b1;
    @(posedge CLK); #1;
    chk_outs("inflight_discarded", 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);

    // First edge after reset release performs the update.
    @(negedge CLK);
    drive(1'b1, 3'd3, 16'h1111, 1'b1, 3'd6, 3'd3, 3'd6, 3'd0);
    @(posedge CLK); #1;
    chk_outs("first_update", 16'h1111, 16'h0000, 16'h0000, 3'b010, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
